// File: rtl/reg_writeback_queue_if.sv
// rtl/reg_writeback_queue_if.sv - producer-side handshake bundle for reg_writeback_queue
//
// Signals:
//    in_valid  producer offers a writeback result
//    in_ready  queue can accept a result this cycle
//    in_reg    destination register id (4 bits)
//    in_data   result value (16 bits)
// Modports: master = producer, slave = queue.
interface reg_writeback_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_reg;
   logic [15:0] in_data;

   modport master (output in_valid, output in_reg, output in_data, input in_ready);
   modport slave  (input in_valid, input in_reg, input in_data, output in_ready);
endinterface

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - circular writeback queue in front of a register-file write port
//
// Ports:
//    clk                   clock, all state updates on posedge
//    rst                   asynchronous active-low reset
//    in_if (slave)         in_valid/in_ready/in_reg/in_data producer handshake
//    flush                 discard all queued entries at the next posedge
//    wb_en/wb_reg/wb_data  register-file write port, driven from the head entry
//    src1_reg/src2_reg     register ids being read this cycle
//    fwdN_hit/fwdN_data    youngest queued value for srcN_reg
//    count                 current occupancy
module reg_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   reg_writeback_queue_if.slave       in_if,
   input  logic                       flush,
   output logic                       wb_en,
   output logic [3:0]                 wb_reg,
   output logic [15:0]                wb_data,
   input  logic [3:0]                 src1_reg,
   input  logic [3:0]                 src2_reg,
   output logic                       fwd1_hit,
   output logic [15:0]                fwd1_data,
   output logic                       fwd2_hit,
   output logic [15:0]                fwd2_data,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [3:0]    reg_mem  [DEPTH];
   logic [15:0]   data_mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          push;
   logic          pop;

   // The register file always accepts, so any presented head retires.
   // Gating in_ready with rst keeps it low for the whole reset window.
   assign in_if.in_ready = rst && (count < CW'(DEPTH)) && !flush;
   assign push           = in_if.in_valid && in_if.in_ready && (in_if.in_reg != 4'd0);
   assign pop            = (count != '0);

   assign wb_en   = pop;
   assign wb_reg  = pop ? reg_mem[head]  : 4'd0;
   assign wb_data = pop ? data_mem[head] : 16'd0;

   // Payload storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         reg_mem[tail]  <= in_if.in_reg;
         data_mem[tail] <= in_if.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Walk valid entries oldest to youngest; a later match overrides an
   // earlier one, so the youngest matching entry wins.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = 16'd0;
      fwd2_hit  = 1'b0;
      fwd2_data = 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] idx;
         idx = head + PW'(i);
         if (CW'(i) < count) begin
            if (src1_reg != 4'd0 && reg_mem[idx] == src1_reg) begin
               fwd1_hit  = 1'b1;
               fwd1_data = data_mem[idx];
            end
            if (src2_reg != 4'd0 && reg_mem[idx] == src2_reg) begin
               fwd2_hit  = 1'b1;
               fwd2_data = data_mem[idx];
            end
         end
      end
   end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - scoreboard bench for reg_writeback_queue
module tb_reg_writeback_queue;
   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0]  r;
      logic [15:0] d;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        wb_en;
   logic [3:0]  wb_reg;
   logic [15:0] wb_data;
   logic [3:0]  src1_reg;
   logic [3:0]  src2_reg;
   logic        fwd1_hit;
   logic [15:0] fwd1_data;
   logic        fwd2_hit;
   logic [15:0] fwd2_data;
   logic [$clog2(DEPTH):0] count;

   reg_writeback_queue_if wif ();

   reg_writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_if     (wif),
      .flush     (flush),
      .wb_en     (wb_en),
      .wb_reg    (wb_reg),
      .wb_data   (wb_data),
      .src1_reg  (src1_reg),
      .src2_reg  (src2_reg),
      .fwd1_hit  (fwd1_hit),
      .fwd1_data (fwd1_data),
      .fwd2_hit  (fwd2_hit),
      .fwd2_data (fwd2_data),
      .count     (count)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t mq[$];      // reference: queue contents as defined by the rules
   ent_t exp_wb[$];  // scoreboard: writes still expected on wb_*

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented write must be the oldest outstanding expected write.
   always @(negedge clk) begin
      if (rst === 1'b1 && wb_en === 1'b1) begin
         if (exp_wb.size() == 0) begin
            chk("unexpected_wb_en", 32'(wb_en), 32'd0);
         end else begin
            ent_t e;
            e = exp_wb.pop_front();
            chk("sb_wb_reg", 32'(wb_reg), 32'(e.r));
            chk("sb_wb_data", 32'(wb_data), 32'(e.d));
         end
      end
   end

   // One cycle: drive at posedge+1, check model against DUT at posedge+4,
   // then advance the model to what the next edge should produce.
   task automatic step(input logic v, input logic [3:0] r, input logic [15:0] d,
                       input logic f, input logic [3:0] s1, input logic [3:0] s2);
      int          sz;
      logic        e_ready, h1, h2, acc;
      logic [15:0] d1, d2;
      wif.in_valid = v;
      wif.in_reg   = r;
      wif.in_data  = d;
      flush        = f;
      src1_reg     = s1;
      src2_reg     = s2;
      #3;
      sz      = mq.size();
      e_ready = rst && (sz < DEPTH) && !f;
      h1 = 1'b0; d1 = 16'd0; h2 = 1'b0; d2 = 16'd0;
      foreach (mq[i]) begin
         if (s1 != 0 && mq[i].r == s1) begin h1 = 1'b1; d1 = mq[i].d; end
         if (s2 != 0 && mq[i].r == s2) begin h2 = 1'b1; d2 = mq[i].d; end
      end
      chk("count", 32'(count), 32'(sz));
      chk("in_ready", 32'(wif.in_ready), 32'(e_ready));
      chk("wb_en", 32'(wb_en), 32'(sz > 0));
      chk("wb_reg", 32'(wb_reg), sz > 0 ? 32'(mq[0].r) : 32'd0);
      chk("wb_data", 32'(wb_data), sz > 0 ? 32'(mq[0].d) : 32'd0);
      chk("fwd1_hit", 32'(fwd1_hit), 32'(h1));
      chk("fwd1_data", 32'(fwd1_data), 32'(d1));
      chk("fwd2_hit", 32'(fwd2_hit), 32'(h2));
      chk("fwd2_data", 32'(fwd2_data), 32'(d2));
      acc = v && e_ready;
      if (f) begin
         // The head is still presented this cycle; everything behind it is lost.
         while (exp_wb.size() > (sz > 0 ? 1 : 0)) void'(exp_wb.pop_back());
         mq.delete();
      end else begin
         if (sz > 0) void'(mq.pop_front());
         if (acc && r != 4'd0) begin
            ent_t e;
            e.r = r;
            e.d = d;
            mq.push_back(e);
            exp_wb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [3:0] s1, input logic [3:0] s2);
      step(1'b0, 4'd0, 16'd0, 1'b0, s1, s2);
   endtask

   initial begin
      rst          = 1'b0;
      wif.in_valid = 1'b0;
      wif.in_reg   = 4'd0;
      wif.in_data  = 16'd0;
      flush        = 1'b0;
      src1_reg     = 4'd1;
      src2_reg     = 4'd2;
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_in_ready", 32'(wif.in_ready), 32'd0);
      chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single write of r5=0x1234.
      step(1'b1, 4'd5, 16'h1234, 1'b0, 4'd5, 4'd0);
      idle(4'd5, 4'd0);
      idle(4'd5, 4'd0);

      // Back-to-back burst of five with continuous drain.
      for (int i = 0; i < 5; i++)
         step(1'b1, 4'(i + 1), 16'(16'h1000 + i), 1'b0, 4'(i + 1), 4'(i));
      idle(4'd0, 4'd0);
      idle(4'd0, 4'd0);

      // Forwarding on repeated r3 writes; src2=0 never hits.
      step(1'b1, 4'd3, 16'h0001, 1'b0, 4'd3, 4'd0);
      step(1'b1, 4'd3, 16'h0002, 1'b0, 4'd3, 4'd0);
      idle(4'd3, 4'd0);
      idle(4'd3, 4'd0);

      // r0 requests complete the handshake but are dropped.
      step(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0);
      idle(4'd0, 4'd0);
      idle(4'd0, 4'd0);

      // Flush with entries pending.
      step(1'b1, 4'd4, 16'h0A0A, 1'b0, 4'd4, 4'd6);
      step(1'b1, 4'd6, 16'h0B0B, 1'b0, 4'd4, 4'd6);
      step(1'b1, 4'd9, 16'h0C0C, 1'b0, 4'd9, 4'd6);
      step(1'b1, 4'd8, 16'h0D0D, 1'b1, 4'd9, 4'd8);
      idle(4'd9, 4'd8);

      // Asynchronous reset mid-cycle with entries pending.
      step(1'b1, 4'd2, 16'h2222, 1'b0, 4'd2, 4'd0);
      step(1'b1, 4'd2, 16'h3333, 1'b0, 4'd2, 4'd0);
      wif.in_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_wb_en", 32'(wb_en), 32'd0);
      chk("async_in_ready", 32'(wif.in_ready), 32'd0);
      chk("async_fwd1_hit", 32'(fwd1_hit), 32'd0);
      chk("async_wb_data", 32'(wb_data), 32'd0);
      mq.delete();
      exp_wb.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd7, 4'd0);
      idle(4'd7, 4'd0);
      idle(4'd7, 4'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] rr;
         rr = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         step(1'($urandom_range(0, 3) != 0), rr, 16'($urandom),
              1'($urandom_range(0, 15) == 0),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      // Bounded drain of anything still expected.
      for (int i = 0; i < 20 && exp_wb.size() > 0; i++) idle(4'd0, 4'd0);
      chk("drain_empty", 32'(exp_wb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
